// File: rtl/lc3b_mem_responder.sv
// LC-3b memory-port responder: word array with byte lanes, WAIT_CYCLES wait states, one-cycle mem_resp.
// Optional protocol checker on proto_err is compiled in with `define LC3B_MEMRESP_PROTCHK_EN.
module lc3b_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Request captured at accept; everything after accept uses this copy.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [1:0]        be;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              req_any_c;
  logic              mem_we_c;
  logic [IDX_W-1:0]  idx_c;
  logic              unused_addr_c;

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign req_any_c     = mem_read | mem_write;
  assign idx_c         = req_q.addr[IDX_W:1];
  assign unused_addr_c = ^req_q.addr;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    resp_d   = 1'b0;
    rdata_d  = rdata_q;
    mem_we_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_any_c) begin
          req_d.addr  = mem_address;
          req_d.wr    = mem_write;
          req_d.be    = mem_byte_enable;
          req_d.wdata = mem_wdata;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!req_any_c) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Access happens on the edge that enters RESP.
          state_d = ST_RESP;
          resp_d  = 1'b1;
          if (req_q.wr) begin
            mem_we_c = 1'b1;
          end else begin
            rdata_d = mem_q[idx_c];
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset; only enabled byte lanes are written.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      if (req_q.be[0]) mem_q[idx_c][7:0]  <= req_q.wdata[7:0];
      if (req_q.be[1]) mem_q[idx_c][15:8] <= req_q.wdata[15:8];
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;

`ifdef LC3B_MEMRESP_PROTCHK_EN
  logic perr_q, perr_d;

  // Sticky flag: dual command, withdrawal in BUSY, or address moving in BUSY.
  always_comb begin
    perr_d = perr_q;
    if ((state_q == ST_IDLE || state_q == ST_BUSY) && mem_read && mem_write) begin
      perr_d = 1'b1;
    end
    if (state_q == ST_BUSY && !req_any_c) begin
      perr_d = 1'b1;
    end
    if (state_q == ST_BUSY && mem_address != req_q.addr) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign proto_err = perr_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: unit 0 with WAIT_CYCLES=2, unit 1 with WAIT_CYCLES=0,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_lc3b_mem_responder;

  localparam int unsigned W_A = 2;
  localparam int unsigned W_B = 0;

  typedef struct {
    int          inst;
    int          cyc;
    bit          wr;
    logic [9:0]  idx;
    logic [1:0]  be;
    logic [15:0] wd;
  } pend_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  rd_i, wr_i;
  logic [15:0] addr_i [2];
  logic [1:0]  be_i [2];
  logic [15:0] wd_i [2];
  logic [15:0] rdata_o [2];
  logic [1:0]  resp_o, perr_o;

  int          cyc;
  int          n_cmp, n_bad;
  pend_t       pq[$];
  logic [15:0] mm [2][1024];
  bit          mk [2][1024];
  logic [15:0] er [2];
  bit          ek [2];
  int          pf [2];
  logic [1:0]  exp_resp;

  lc3b_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(W_A)) u_a (
    .clk(clk), .rst_n(rst_n), .mem_address(addr_i[0]), .mem_read(rd_i[0]),
    .mem_write(wr_i[0]), .mem_byte_enable(be_i[0]), .mem_wdata(wd_i[0]),
    .mem_rdata(rdata_o[0]), .mem_resp(resp_o[0]), .proto_err(perr_o[0]));

  lc3b_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(W_B)) u_b (
    .clk(clk), .rst_n(rst_n), .mem_address(addr_i[1]), .mem_read(rd_i[1]),
    .mem_write(wr_i[1]), .mem_byte_enable(be_i[1]), .mem_wdata(wd_i[1]),
    .mem_rdata(rdata_o[1]), .mem_resp(resp_o[1]), .proto_err(perr_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int waits(input int s);
    return (s == 0) ? int'(W_A) : int'(W_B);
  endfunction

  function automatic logic exp_perr(input int s);
`ifdef LC3B_MEMRESP_PROTCHK_EN
    return (pf[s] >= 0 && cyc >= pf[s]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic note_perr(input int s, input int from);
    if (pf[s] < 0 || from < pf[s]) pf[s] = from;
  endtask

  task automatic model_reset();
    pq.delete();
    for (int s = 0; s < 2; s++) begin
      er[s] = 16'h0000;
      ek[s] = 1'b1;
      pf[s] = -1;
    end
  endtask

  task automatic set_in(input int s, input logic rd, input logic wr, input logic [15:0] a,
                        input logic [1:0] be, input logic [15:0] wd);
    rd_i[s]   = rd;
    wr_i[s]   = wr;
    addr_i[s] = a;
    be_i[s]   = be;
    wd_i[s]   = wd;
  endtask

  // Model: completions land at request cycle + 2 + wait states; compare every cycle.
  always @(negedge clk) begin
    exp_resp = 2'b00;
    for (int i = pq.size() - 1; i >= 0; i--) begin
      if (pq[i].cyc == cyc) begin
        exp_resp[pq[i].inst] = 1'b1;
        if (pq[i].wr) begin
          if (pq[i].be[0]) mm[pq[i].inst][pq[i].idx][7:0]  = pq[i].wd[7:0];
          if (pq[i].be[1]) mm[pq[i].inst][pq[i].idx][15:8] = pq[i].wd[15:8];
          if (pq[i].be == 2'b11) mk[pq[i].inst][pq[i].idx] = 1'b1;
        end else begin
          er[pq[i].inst] = mm[pq[i].inst][pq[i].idx];
          ek[pq[i].inst] = mk[pq[i].inst][pq[i].idx];
        end
        pq.delete(i);
      end
    end
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("u%0d mem_resp", s), 16'(resp_o[s]), 16'(exp_resp[s]));
      if (ek[s]) chk($sformatf("u%0d mem_rdata", s), rdata_o[s], er[s]);
      chk($sformatf("u%0d proto_err", s), 16'(perr_o[s]), 16'(exp_perr(s)));
    end
  end

  task automatic xact(input int s, input logic rd, input logic wr, input logic [15:0] a,
                      input logic [1:0] be, input logic [15:0] wd,
                      output int lat, output logic [15:0] dat);
    int n;
    bit got;
    @(posedge clk); #1;
    n = cyc;
    pq.push_back('{inst: s, cyc: n + 2 + waits(s), wr: wr, idx: a[10:1], be: be, wd: wd});
    if (rd && wr) note_perr(s, n + 1);
    set_in(s, rd, wr, a, be, wd);
    got = 1'b0;
    lat = -1;
    dat = 16'h0000;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (resp_o[s]) begin
        got = 1'b1;
        lat = cyc - n;
        dat = rdata_o[s];
      end
    end
    chk($sformatf("u%0d resp_seen a=%h", s, a), 16'(got), 16'd1);
    @(posedge clk); #1;
    set_in(s, 1'b0, 1'b0, a, be, wd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [15:0] d;
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) set_in(s, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Timing and basic write/read on the WAIT_CYCLES=2 unit.
    xact(0, 1'b0, 1'b1, 16'h0040, 2'b11, 16'hBEEF, lat, d);
    chk("u0 write latency", 16'(lat), 16'd4);
    xact(0, 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000, lat, d);
    chk("u0 read latency", 16'(lat), 16'd4);
    chk("u0 read 0040", d, 16'hBEEF);
    xact(0, 1'b1, 1'b0, 16'h0041, 2'b00, 16'h0000, lat, d);
    chk("u0 read odd 0041", d, 16'hBEEF);

    // Byte lanes.
    xact(0, 1'b0, 1'b1, 16'h0010, 2'b11, 16'h1234, lat, d);
    xact(0, 1'b0, 1'b1, 16'h0010, 2'b01, 16'hAACD, lat, d);
    xact(0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, d);
    chk("u0 lane0 write", d, 16'h12CD);
    xact(0, 1'b0, 1'b1, 16'h0010, 2'b10, 16'h77FF, lat, d);
    xact(0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, d);
    chk("u0 lane1 write", d, 16'h77CD);
    xact(0, 1'b0, 1'b1, 16'h0010, 2'b00, 16'hFFFF, lat, d);
    xact(0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, lat, d);
    chk("u0 mask00 write", d, 16'h77CD);

    // Address wrap modulo 2*DEPTH bytes.
    xact(0, 1'b0, 1'b1, 16'h0800, 2'b11, 16'h5A5A, lat, d);
    xact(0, 1'b1, 1'b0, 16'h0000, 2'b00, 16'h0000, lat, d);
    chk("u0 wrap read 0000", d, 16'h5A5A);

    // Read and write together: write wins, read data untouched.
    xact(0, 1'b1, 1'b1, 16'h0030, 2'b11, 16'h3C3C, lat, d);
    chk("u0 rw rdata held", d, 16'h5A5A);
    xact(0, 1'b1, 1'b0, 16'h0030, 2'b00, 16'h0000, lat, d);
    chk("u0 rw write landed", d, 16'h3C3C);

    // Withdrawal mid-BUSY.
    xact(0, 1'b0, 1'b1, 16'h0060, 2'b11, 16'h6666, lat, d);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b1, 16'h0060, 2'b11, 16'h9999);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0, 16'h0060, 2'b11, 16'h9999);
    note_perr(0, cyc + 1);
    repeat (6) @(posedge clk);
    #1;
`ifdef LC3B_MEMRESP_PROTCHK_EN
    chk("u0 proto_err after withdraw", 16'(perr_o[0]), 16'd1);
`else
    chk("u0 proto_err after withdraw", 16'(perr_o[0]), 16'd0);
`endif
    xact(0, 1'b1, 1'b0, 16'h0060, 2'b00, 16'h0000, lat, d);
    chk("u0 withdraw readback", d, 16'h6666);

    // Reset in BUSY of a write.
    xact(0, 1'b0, 1'b1, 16'h0020, 2'b11, 16'h1111, lat, d);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b1, 16'h0020, 2'b11, 16'h2222);
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_in(0, 1'b0, 1'b0, 16'h0020, 2'b11, 16'h2222);
    model_reset();
    #1;
    chk("u0 resp in reset", 16'(resp_o[0]), 16'd0);
    chk("u0 rdata in reset", rdata_o[0], 16'h0000);
    chk("u0 proto_err in reset", 16'(perr_o[0]), 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    xact(0, 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, lat, d);
    chk("u0 reset readback", d, 16'h1111);

    // Back-to-back traffic on the WAIT_CYCLES=0 unit.
    xact(1, 1'b0, 1'b1, 16'h0100, 2'b11, 16'hA1A1, lat, d);
    chk("u1 write latency", 16'(lat), 16'd2);
    xact(1, 1'b0, 1'b1, 16'h0102, 2'b11, 16'hB2B2, lat, d);
    xact(1, 1'b1, 1'b0, 16'h0100, 2'b00, 16'h0000, lat, d);
    chk("u1 read latency a", 16'(lat), 16'd2);
    chk("u1 read 0100", d, 16'hA1A1);
    xact(1, 1'b1, 1'b0, 16'h0102, 2'b00, 16'h0000, lat, d);
    chk("u1 read latency b", 16'(lat), 16'd2);
    chk("u1 read 0102", d, 16'hB2B2);
    xact(1, 1'b1, 1'b0, 16'h0101, 2'b00, 16'h0000, lat, d);
    chk("u1 read odd 0101", d, 16'hA1A1);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
